// File: rtl/exe_mem_reg.sv
// EXE->MEM pipeline register with a one-entry skid buffer, so in_ready is
// fully registered, plus a saturating counter of back-pressure cycles.
module exe_mem_reg #(
  parameter int DATA_W = 16,
  parameter int RD_W   = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] alu_result_in,
  input  logic [DATA_W-1:0] store_data_in,
  input  logic [DATA_W-1:0] pc_plus2_in,
  input  logic [RD_W-1:0]   rd_in,
  input  logic              mem_read_in,
  input  logic              mem_write_in,
  input  logic              reg_write_in,
  input  logic              flush,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] alu_result_out,
  output logic [DATA_W-1:0] store_data_out,
  output logic [DATA_W-1:0] pc_plus2_out,
  output logic [RD_W-1:0]   rd_out,
  output logic              mem_read_out,
  output logic              mem_write_out,
  output logic              reg_write_out,
  output logic [7:0]        stall_cnt
);

  typedef enum logic [1:0] {
    EMPTY     = 2'd0,
    FULL      = 2'd1,
    SKID_FULL = 2'd2
  } state_t;

  typedef struct packed {
    logic [DATA_W-1:0] alu_result;
    logic [DATA_W-1:0] store_data;
    logic [DATA_W-1:0] pc_plus2;
    logic [RD_W-1:0]   rd;
    logic              mem_read;
    logic              mem_write;
    logic              reg_write;
  } payload_t;

  state_t   state, state_nxt;
  payload_t main_q, skid_q, in_pl;
  logic     in_xfer, out_xfer;
  logic     main_from_in, main_from_skid, skid_from_in;

  assign in_pl = '{alu_result: alu_result_in, store_data: store_data_in,
                   pc_plus2: pc_plus2_in, rd: rd_in, mem_read: mem_read_in,
                   mem_write: mem_write_in, reg_write: reg_write_in};

  // Handshake outputs depend on registered state only.
  assign in_ready  = (state != SKID_FULL);
  assign out_valid = (state != EMPTY);
  assign in_xfer   = in_valid && in_ready;
  assign out_xfer  = out_valid && out_ready;

  always_comb begin
    // NOTE: every output of this block gets a default first, so no path
    // through the case can leave a value unassigned and infer a latch.
    state_nxt      = state;
    main_from_in   = 1'b0;
    main_from_skid = 1'b0;
    skid_from_in   = 1'b0;
    if (flush) begin
      state_nxt = EMPTY;
    end else begin
      unique case (state)
        EMPTY: begin
          if (in_xfer) begin
            main_from_in = 1'b1;
            state_nxt    = FULL;
          end
        end
        FULL: begin
          if (in_xfer && out_xfer) begin
            main_from_in = 1'b1;
          end else if (out_xfer) begin
            state_nxt = EMPTY;
          end else if (in_xfer) begin
            skid_from_in = 1'b1;
            state_nxt    = SKID_FULL;
          end
        end
        SKID_FULL: begin
          if (out_xfer) begin
            main_from_skid = 1'b1;
            state_nxt      = FULL;
          end
        end
        default: state_nxt = EMPTY;
      endcase
    end
  end

  // NOTE: state updates use non-blocking assignments so every flop samples
  // pre-edge values regardless of process evaluation order.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= EMPTY;
    else        state <= state_nxt;
  end

  // NOTE: payload flops are reset because outputs must read zero during reset.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      main_q <= '0;
      skid_q <= '0;
    end else begin
      if (main_from_in)        main_q <= in_pl;
      else if (main_from_skid) main_q <= skid_q;
      if (skid_from_in)        skid_q <= in_pl;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)                                 stall_cnt <= 8'd0;
    else if (out_valid && !out_ready && stall_cnt != 8'hFF) stall_cnt <= stall_cnt + 8'd1;
  end

  assign alu_result_out = main_q.alu_result;
  assign store_data_out = main_q.store_data;
  assign pc_plus2_out   = main_q.pc_plus2;
  assign rd_out         = main_q.rd;
  assign mem_read_out   = out_valid && main_q.mem_read;
  assign mem_write_out  = out_valid && main_q.mem_write;
  assign reg_write_out  = out_valid && main_q.reg_write;

endmodule

// File: tb/tb_exe_mem_reg.sv
// Scoreboard bench for exe_mem_reg: accepted inputs are queued, a negedge
// monitor pops and compares every output transfer.
module tb_exe_mem_reg;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid, in_ready, flush, out_valid, out_ready;
  logic [15:0] alu_result_in, store_data_in, pc_plus2_in;
  logic [3:0]  rd_in;
  logic        mem_read_in, mem_write_in, reg_write_in;
  logic [15:0] alu_result_out, store_data_out, pc_plus2_out;
  logic [3:0]  rd_out;
  logic        mem_read_out, mem_write_out, reg_write_out;
  logic [7:0]  stall_cnt;

  int n_checks = 0;
  int n_fail   = 0;
  int out_count = 0;
  logic [54:0] exp_q[$];

  exe_mem_reg #(.DATA_W(16), .RD_W(4)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .alu_result_in(alu_result_in), .store_data_in(store_data_in),
    .pc_plus2_in(pc_plus2_in), .rd_in(rd_in), .mem_read_in(mem_read_in),
    .mem_write_in(mem_write_in), .reg_write_in(reg_write_in), .flush(flush),
    .out_valid(out_valid), .out_ready(out_ready),
    .alu_result_out(alu_result_out), .store_data_out(store_data_out),
    .pc_plus2_out(pc_plus2_out), .rd_out(rd_out), .mem_read_out(mem_read_out),
    .mem_write_out(mem_write_out), .reg_write_out(reg_write_out),
    .stall_cnt(stall_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Drive one cycle's worth of inputs; store data and pc are derived from alu.
  task automatic drive(input logic v, input logic [15:0] alu, input logic [3:0] rd,
                       input logic rw, input logic mr, input logic mw,
                       input logic fl, input logic ordy);
    in_valid      = v;
    alu_result_in = alu;
    store_data_in = alu ^ 16'hA5A5;
    pc_plus2_in   = alu + 16'd2;
    rd_in         = rd;
    reg_write_in  = rw;
    mem_read_in   = mr;
    mem_write_in  = mw;
    flush         = fl;
    out_ready     = ordy;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input logic ordy, input int n);
    for (int i = 0; i < n; i++) begin
      drive(1'b0, 16'h0, 4'h0, 1'b0, 1'b0, 1'b0, 1'b0, ordy);
      tick();
    end
  endtask

  // Scoreboard: pop on output transfer, push on input transfer, clear on flush/reset.
  always @(negedge clk) begin
    if (!reset) begin
      exp_q.delete();
    end else begin
      if (out_valid && out_ready && !flush) begin
        out_count++;
        if (exp_q.size() == 0) begin
          check("unexpected_output", {9'd0, alu_result_out, store_data_out, pc_plus2_out,
                rd_out, mem_read_out, mem_write_out, reg_write_out}, 64'hDEAD);
        end else begin
          check("out_payload", {9'd0, alu_result_out, store_data_out, pc_plus2_out,
                rd_out, mem_read_out, mem_write_out, reg_write_out},
                {9'd0, exp_q.pop_front()});
        end
      end
      if (in_valid && in_ready && !flush)
        exp_q.push_back({alu_result_in, store_data_in, pc_plus2_in, rd_in,
                         mem_read_in, mem_write_in, reg_write_in});
      if (flush) exp_q.delete();
    end
  end

  initial begin
    int base;
    reset = 1'b0;
    drive(1'b0, 16'h0, 4'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    #3;
    check("rst_out_valid", out_valid, 1'b0);
    check("rst_in_ready", in_ready, 1'b1);
    check("rst_stall_cnt", stall_cnt, 8'd0);
    check("rst_payload", {alu_result_out, rd_out, reg_write_out}, '0);
    tick();
    tick();
    reset = 1'b1;

    // First transfer visible one cycle after acceptance.
    drive(1'b1, 16'h0064, 4'd10, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
    tick();
    drive(1'b0, 16'h0, 4'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    check("first_out_valid", out_valid, 1'b1);
    check("first_alu", alu_result_out, 16'h0064);
    check("first_rd", rd_out, 4'd10);
    check("first_reg_write", reg_write_out, 1'b1);
    idle(1'b1, 2);

    // Full-rate streaming, values 1..8.
    base = out_count;
    for (int i = 1; i <= 8; i++) begin
      drive(1'b1, 16'(i), 4'(i), i[0], i[1], i[2], 1'b0, 1'b1);
      tick();
    end
    idle(1'b1, 3);
    check("stream_out_count", out_count - base, 8);
    check("stream_stall_cnt", stall_cnt, 8'd0);

    // Back-pressure fills the skid entry; third input is refused until drained.
    base = out_count;
    drive(1'b1, 16'h0065, 4'd1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    tick();
    drive(1'b1, 16'h0066, 4'd2, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    tick();
    check("skid_in_ready", in_ready, 1'b0);
    drive(1'b1, 16'h0067, 4'd3, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    tick();
    check("skid_hold_alu", alu_result_out, 16'h0065);
    drive(1'b1, 16'h0067, 4'd3, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
    tick();
    tick();
    idle(1'b1, 3);
    check("skid_out_count", out_count - base, 3);
    check("skid_stall_cnt", stall_cnt, 8'd2);

    // Flush from SKID_FULL drops both entries and the simultaneous input.
    drive(1'b1, 16'h0070, 4'd4, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    tick();
    drive(1'b1, 16'h0071, 4'd5, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
    tick();
    drive(1'b1, 16'h0099, 4'd6, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0);
    tick();
    drive(1'b0, 16'h0, 4'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    check("flush_out_valid", out_valid, 1'b0);
    check("flush_in_ready", in_ready, 1'b1);
    check("flush_ctrl", {mem_read_out, mem_write_out, reg_write_out}, 3'b000);
    check("flush_payload_kept", alu_result_out, 16'h0070);
    check("flush_stall_cnt", stall_cnt, 8'd4);
    idle(1'b1, 3);

    // Long stall saturates the counter.
    drive(1'b1, 16'h0080, 4'd7, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    tick();
    idle(1'b0, 260);
    check("stall_sat", stall_cnt, 8'd255);
    idle(1'b0, 40);
    check("stall_sat_hold", stall_cnt, 8'd255);
    idle(1'b1, 3);
    check("stall_after_drain", stall_cnt, 8'd255);

    // Asynchronous reset between edges while SKID_FULL.
    drive(1'b1, 16'h00A0, 4'd8, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    tick();
    drive(1'b1, 16'h00A1, 4'd9, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    tick();
    drive(1'b0, 16'h0, 4'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    #1;
    reset = 1'b0;
    #1;
    check("arst_out_valid", out_valid, 1'b0);
    check("arst_in_ready", in_ready, 1'b1);
    check("arst_stall_cnt", stall_cnt, 8'd0);
    check("arst_payload", {alu_result_out, reg_write_out}, '0);
    tick();
    reset = 1'b1;
    base = out_count;
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 16'h00B0 + 16'(i), 4'(11 + i), 1'b1, 1'b0, 1'b1, 1'b0, 1'b1);
      tick();
    end
    idle(1'b1, 3);
    check("resume_out_count", out_count - base, 3);
    check("queue_drained", exp_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/exe_mem_reg.md
EXE_MEM_REG -- requirements
Module: exe_mem_reg

Interface
REQ-001 SHALL have parameter DATA_W, default 16, width of the data paths (alu result, store data, pc_plus2).
REQ-002 SHALL have parameter RD_W, default 4, width of the destination-register index.
REQ-003 SHALL have port clk  input  1  the single clock; all state updates on rising edge.
REQ-004 SHALL have port reset  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port in_valid  input  1  EXE stage presents a result.
REQ-006 SHALL have port in_ready  output  1  register accepts a result this cycle.
REQ-007 SHALL have ports alu_result_in, store_data_in, pc_plus2_in  input  DATA_W  EXE payload.
REQ-008 SHALL have port rd_in  input  RD_W  destination register.
REQ-009 SHALL have ports mem_read_in, mem_write_in, reg_write_in  input  1  control bits.
REQ-010 SHALL have port flush  input  1  synchronous discard of all held entries.
REQ-011 SHALL have port out_valid  output  1  MEM stage payload valid.
REQ-012 SHALL have port out_ready  input  1  MEM stage accepts payload.
REQ-013 SHALL have ports alu_result_out, store_data_out, pc_plus2_out (DATA_W), rd_out (RD_W), mem_read_out, mem_write_out, reg_write_out (1)  output  registered payload.
REQ-014 SHALL have port stall_cnt  output  8  saturating count of back-pressure cycles.

Function
REQ-015 SHALL hold two entries, MAIN (drives outputs) and SKID, with states EMPTY, FULL (MAIN only), SKID_FULL (both).
REQ-016 SHALL transfer on input when in_valid && in_ready, on output when out_valid && out_ready.
REQ-017 SHALL drive in_ready = 1 in EMPTY and FULL, 0 in SKID_FULL, from registered state only (no combinational path from out_ready).
REQ-018 SHALL drive out_valid = 1 in FULL and SKID_FULL, 0 in EMPTY.
REQ-019 EMPTY: input transfer -> load MAIN, go FULL; payload visible at outputs one cycle after acceptance.
REQ-020 FULL: input and output transfer together -> MAIN takes new payload, stay FULL; output only -> EMPTY; input only -> load SKID, go SKID_FULL.
REQ-021 SKID_FULL: output transfer -> MAIN takes SKID contents, go FULL; otherwise hold.
REQ-022 SHALL keep all payload outputs stable while out_valid && !out_ready.
REQ-023 flush SHALL take priority over every transfer: next state EMPTY, any simultaneous input dropped, payload outputs keep last values.
REQ-024 SHALL preserve ordering; no entry duplicated or lost except by flush.
REQ-025 stall_cnt SHALL increment each cycle out_valid && !out_ready, saturate at 255, never wrap, and is unaffected by flush.
REQ-026 Payload outputs in EMPTY SHALL be don't-care to consumers; control outputs gated: mem_read_out, mem_write_out, reg_write_out = 0 whenever out_valid = 0.

Reset
REQ-027 reset low SHALL immediately force EMPTY, out_valid = 0, in_ready = 1, all payload/control outputs = 0, stall_cnt = 0, independent of clk.
REQ-028 Reset asserted mid-operation SHALL discard both entries; first acceptance after release occurs on the first rising edge with reset high and in_valid high.

Verification
REQ-029 Reset low, then high; in_valid=1, alu_result_in=16'h0064, rd_in=10, reg_write_in=1, out_ready=1 -> next cycle out_valid=1, alu_result_out=16'h0064, rd_out=10, reg_write_out=1.
REQ-030 out_ready=0, send 16'h0065 then 16'h0066 -> in_ready=0 after second; third input 16'h0067 not accepted; out_ready=1 -> outputs 16'h0065, 16'h0066, then 16'h0067 in order.
REQ-031 Streaming in_valid=1, out_ready=1 for 8 cycles, values 1..8 -> one output per cycle, values 1..8, stall_cnt=0.
REQ-032 SKID_FULL, flush=1 with in_valid=1 (16'h0099) -> next cycle out_valid=0, in_ready=1, 16'h0099 never appears, control outputs 0.
REQ-033 Hold out_ready=0 with out_valid=1 for 300 cycles -> stall_cnt reaches 255 and stays 255.
REQ-034 Assert reset low between clock edges while SKID_FULL -> out_valid=0, stall_cnt=0 before next edge; resume stream accepted cleanly.
